// File: rtl/intra_tucoordgen.sv
// Sequential intra TU coordinate generator: one luma TU descriptor in, a stream of
// absolute per-component TU coordinates out in Y, Cb, Cr order.
module intra_tucoordgen #(
  parameter int CHROMA_FMT = 1,
  parameter int CTB_LOG2   = 6,
  parameter int XCTB_W     = 9,
  parameter int COORD_W    = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [XCTB_W-1:0]   xCtb,
  input  logic [XCTB_W-1:0]   yCtb,
  input  logic [CTB_LOG2-3:0] xTb_rela,
  input  logic [CTB_LOG2-3:0] yTb_rela,
  input  logic [2:0]          i_tuSize,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [COORD_W-1:0]  o_xTb,
  output logic [COORD_W-1:0]  o_yTb,
  output logic [2:0]          o_tuSize,
  output logic [1:0]          o_cIdx,
  output logic                o_last,
  output logic [2:0]          dbg_state
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high at the
  // clock edge; valid never drops and payload never changes until that transfer.

  typedef enum logic [2:0] {IDLE, Y, CB0, CB1, CR0, CR1} state_t;

  state_t state;

  logic [COORD_W-1:0] xl, yl, xb, yb, cx, cy;
  logic [2:0]         csize;
  logic               quad, emit_c;
  logic               transfer, capture;

  logic [COORD_W-1:0] c_x, c_y, c_y1;
  logic [2:0]         c_size;

  always_comb begin
    xl     = (COORD_W'(xCtb) << CTB_LOG2) + (COORD_W'(xTb_rela) << 2);
    yl     = (COORD_W'(yCtb) << CTB_LOG2) + (COORD_W'(yTb_rela) << 2);
    quad   = (CHROMA_FMT == 1 || CHROMA_FMT == 2) && (i_tuSize == 3'd2);
    // Subsampled chroma of a 4x4 luma quad is sent once, with the quad's last 4x4.
    emit_c = (CHROMA_FMT != 0) && (!quad || (xTb_rela[0] && yTb_rela[0]));
    xb     = quad ? xl - COORD_W'(4) : xl;
    yb     = quad ? yl - COORD_W'(4) : yl;
    if (CHROMA_FMT == 3) begin
      cx    = xl;
      cy    = yl;
      csize = i_tuSize;
    end else begin
      cx    = xb >> 1;
      cy    = (CHROMA_FMT == 2) ? yb : (yb >> 1);
      csize = quad ? 3'd2 : (i_tuSize - 3'd1);
    end
  end

  assign transfer  = o_valid && o_ready;
  assign i_ready   = (state == IDLE) || (transfer && o_last);
  assign capture   = i_valid && i_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_xTb    <= '0;
      o_yTb    <= '0;
      o_tuSize <= '0;
      o_cIdx   <= '0;
      o_last   <= 1'b0;
      c_x      <= '0;
      c_y      <= '0;
      c_y1     <= '0;
      c_size   <= '0;
    end else if (capture) begin
      state    <= Y;
      o_valid  <= 1'b1;
      o_xTb    <= xl;
      o_yTb    <= yl;
      o_tuSize <= i_tuSize;
      o_cIdx   <= 2'd0;
      o_last   <= !emit_c;
      c_x      <= cx;
      c_y      <= cy;
      c_y1     <= cy + (COORD_W'(1) << csize);
      c_size   <= csize;
    end else if (transfer) begin
      if (o_last) begin
        state   <= IDLE;
        o_valid <= 1'b0;
      end else begin
        case (state)
          Y: begin
            state    <= CB0;
            o_xTb    <= c_x;
            o_yTb    <= c_y;
            o_tuSize <= c_size;
            o_cIdx   <= 2'd1;
            o_last   <= 1'b0;
          end
          CB0: begin
            // 4:2:2 chroma is two stacked squares; the lower one follows directly.
            if (CHROMA_FMT == 2) begin
              state <= CB1;
              o_yTb <= c_y1;
            end else begin
              state  <= CR0;
              o_yTb  <= c_y;
              o_cIdx <= 2'd2;
              o_last <= 1'b1;
            end
          end
          CB1: begin
            state  <= CR0;
            o_yTb  <= c_y;
            o_cIdx <= 2'd2;
            o_last <= 1'b0;
          end
          CR0: begin
            state  <= CR1;
            o_yTb  <= c_y1;
            o_last <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intra_tucoordgen.sv
// Directed bench for intra_tucoordgen: 4:2:0, 4:2:2 and monochrome instances share
// one input stream; each scenario checks the instance it targets.
module tb_intra_tucoordgen;

  localparam int CTB_LOG2 = 6;
  localparam int XCTB_W   = 9;
  localparam int COORD_W  = 13;
  localparam int OW       = 1 + 2 * COORD_W + 3 + 2 + 1;

  logic clk, rst, i_valid, o_ready;
  logic [XCTB_W-1:0]   xCtb, yCtb;
  logic [CTB_LOG2-3:0] xTb_rela, yTb_rela;
  logic [2:0]          i_tuSize;

  logic               rdy1, v1, l1, rdy2, v2, l2, rdy0, v0, l0;
  logic [COORD_W-1:0] x1, y1, x2, y2, x0, y0;
  logic [2:0]         s1, s2, s0, st1, st2, st0;
  logic [1:0]         c1, c2, c0;

  wire [OW-1:0] out1 = {v1, x1, y1, s1, c1, l1};
  wire [OW-1:0] out2 = {v2, x2, y2, s2, c2, l2};
  wire [OW-1:0] out0 = {v0, x0, y0, s0, c0, l0};

  int vectors = 0;
  int miscompares = 0;
  logic [OW-1:0] exp_q[$];

  intra_tucoordgen #(.CHROMA_FMT(1), .CTB_LOG2(CTB_LOG2), .XCTB_W(XCTB_W), .COORD_W(COORD_W)) u_fmt1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy1), .xCtb(xCtb), .yCtb(yCtb),
    .xTb_rela(xTb_rela), .yTb_rela(yTb_rela), .i_tuSize(i_tuSize), .o_valid(v1), .o_ready(o_ready),
    .o_xTb(x1), .o_yTb(y1), .o_tuSize(s1), .o_cIdx(c1), .o_last(l1), .dbg_state(st1));

  intra_tucoordgen #(.CHROMA_FMT(2), .CTB_LOG2(CTB_LOG2), .XCTB_W(XCTB_W), .COORD_W(COORD_W)) u_fmt2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy2), .xCtb(xCtb), .yCtb(yCtb),
    .xTb_rela(xTb_rela), .yTb_rela(yTb_rela), .i_tuSize(i_tuSize), .o_valid(v2), .o_ready(o_ready),
    .o_xTb(x2), .o_yTb(y2), .o_tuSize(s2), .o_cIdx(c2), .o_last(l2), .dbg_state(st2));

  intra_tucoordgen #(.CHROMA_FMT(0), .CTB_LOG2(CTB_LOG2), .XCTB_W(XCTB_W), .COORD_W(COORD_W)) u_fmt0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy0), .xCtb(xCtb), .yCtb(yCtb),
    .xTb_rela(xTb_rela), .yTb_rela(yTb_rela), .i_tuSize(i_tuSize), .o_valid(v0), .o_ready(o_ready),
    .o_xTb(x0), .o_yTb(y0), .o_tuSize(s0), .o_cIdx(c0), .o_last(l0), .dbg_state(st0));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output word: valid, x, y, log2 size, cIdx, last
  function automatic logic [OW-1:0] ov(input int x, input int y, input int s, input int c, input int l);
    return {1'b1, COORD_W'(x), COORD_W'(y), 3'(s), 2'(c), 1'(l)};
  endfunction

  // Drivers (inputs change on the falling edge, outputs are sampled there too)
  task automatic drive(input int xc, input int yc, input int xr, input int yr, input int sz);
    i_valid  = 1'b1;
    xCtb     = XCTB_W'(xc);
    yCtb     = XCTB_W'(yc);
    xTb_rela = (CTB_LOG2-2)'(xr);
    yTb_rela = (CTB_LOG2-2)'(yr);
    i_tuSize = 3'(sz);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    o_ready = 1'b1;
    drive(3, 2, 5, 6, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (out1 !== '0 || st1 !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %h state %0d, expected 0 state 0", i, out1, st1);
      end
    end
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdy1 !== 1'b1 || out1 !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got i_ready %b out %h, expected i_ready 1 out 0", rdy1, out1);
    end
  endtask

  task automatic test_plain_420();
    logic [OW-1:0] exp;
    do_reset();
    exp_q = {ov(144, 96, 4, 0, 0), ov(72, 48, 3, 1, 0), ov(72, 48, 3, 2, 1)};
    drive(2, 1, 4, 8, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) i_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (out1 !== exp) begin
        miscompares++;
        $display("FAIL plain_420[%0d]: got %h expected %h", i, out1, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (v1 !== 1'b0) begin
      miscompares++;
      $display("FAIL plain_420_idle: got o_valid %b expected 0", v1);
    end
  endtask

  task automatic test_quad_420();
    logic [OW-1:0] exp;
    int rx[4] = '{0, 1, 0, 1};
    int ry[4] = '{0, 0, 1, 1};
    do_reset();
    exp_q = {ov(0, 0, 2, 0, 1), ov(4, 0, 2, 0, 1), ov(0, 4, 2, 0, 1),
             ov(4, 4, 2, 0, 0), ov(0, 0, 2, 1, 0), ov(0, 0, 2, 2, 1)};
    drive(0, 0, rx[0], ry[0], 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (out1 !== exp) begin
        miscompares++;
        $display("FAIL quad_420[%0d]: got %h expected %h", i, out1, exp);
      end
      if (i < 3) begin
        vectors++;
        if (rdy1 !== 1'b1) begin
          miscompares++;
          $display("FAIL quad_420_ready[%0d]: got %b expected 1", i, rdy1);
        end
        drive(0, 0, rx[i+1], ry[i+1], 2);
      end else begin
        i_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back_422();
    logic [OW-1:0] exp;
    do_reset();
    exp_q = {ov(8, 8, 3, 0, 0), ov(4, 8, 2, 1, 0), ov(4, 12, 2, 1, 0),
             ov(4, 8, 2, 2, 0), ov(4, 12, 2, 2, 1),
             ov(68, 4, 2, 0, 0), ov(32, 0, 2, 1, 0), ov(32, 4, 2, 1, 0),
             ov(32, 0, 2, 2, 0), ov(32, 4, 2, 2, 1)};
    drive(0, 0, 2, 2, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (out2 !== exp) begin
        miscompares++;
        $display("FAIL seq_422[%0d]: got %h expected %h", i, out2, exp);
      end
      if (i == 4) begin
        vectors++;
        if (rdy2 !== 1'b1) begin
          miscompares++;
          $display("FAIL seq_422_ready: got %b expected 1", rdy2);
        end
        drive(1, 0, 1, 1, 2);
      end else begin
        i_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (v2 !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_422_idle: got o_valid %b expected 0", v2);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] exp;
    do_reset();
    drive(0, 0, 2, 0, 3);
    @(negedge clk);
    vectors++;
    if (out1 !== ov(8, 0, 3, 0, 0)) begin
      miscompares++;
      $display("FAIL bp_y: got %h expected %h", out1, ov(8, 0, 3, 0, 0));
    end
    drive(1, 2, 0, 0, 5);
    @(negedge clk);
    o_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (out1 !== ov(4, 0, 2, 1, 0) || rdy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h i_ready %b, expected %h i_ready 0", i, out1, rdy1, ov(4, 0, 2, 1, 0));
      end
    end
    o_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out1 !== ov(4, 0, 2, 2, 1) || rdy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_cr: got %h i_ready %b, expected %h i_ready 1", out1, rdy1, ov(4, 0, 2, 2, 1));
    end
    exp_q = {ov(64, 128, 5, 0, 0), ov(32, 64, 4, 1, 0), ov(32, 64, 4, 2, 1)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (out1 !== exp) begin
        miscompares++;
        $display("FAIL bp_next[%0d]: got %h expected %h", i, out1, exp);
      end
    end
  endtask

  task automatic test_mono();
    logic [OW-1:0] exp;
    do_reset();
    // Third descriptor wraps the 13-bit coordinate: 511*64+60 = 32764 -> 8188.
    exp_q = {ov(12, 20, 2, 0, 1), ov(192, 0, 5, 0, 1), ov(8188, 8188, 2, 0, 1)};
    drive(0, 0, 3, 5, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (out0 !== exp || rdy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL mono[%0d]: got %h i_ready %b, expected %h i_ready 1", i, out0, rdy0, exp);
      end
      if (i == 0) drive(3, 0, 0, 0, 5);
      else if (i == 1) drive(511, 511, 15, 15, 2);
      else i_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (v0 !== 1'b0) begin
      miscompares++;
      $display("FAIL mono_idle: got o_valid %b expected 0", v0);
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] exp;
    do_reset();
    drive(1, 1, 1, 1, 4);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out1 !== ov(34, 34, 3, 1, 0)) begin
      miscompares++;
      $display("FAIL rmid_cb: got %h expected %h", out1, ov(34, 34, 3, 1, 0));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out1 !== '0 || st1 !== 3'd0) begin
      miscompares++;
      $display("FAIL rmid_cleared: got %h state %0d, expected 0 state 0", out1, st1);
    end
    drive(0, 1, 0, 2, 3);
    exp_q = {ov(0, 72, 3, 0, 0), ov(0, 36, 2, 1, 0), ov(0, 36, 2, 2, 1)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (out1 !== exp) begin
        miscompares++;
        $display("FAIL rmid_restart[%0d]: got %h expected %h", i, out1, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    xCtb = '0;
    yCtb = '0;
    xTb_rela = '0;
    yTb_rela = '0;
    i_tuSize = 3'd2;
    test_reset();
    test_plain_420();
    test_quad_420();
    test_back_to_back_422();
    test_backpressure();
    test_mono();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intra_tucoordgen.md
Name: intra_tuCoordGen

Overview:
Sequential successor to the combinational intra TU coordinate transform. Accepts one luma TU descriptor per handshake: CTB position, TU offset inside the CTB in 4x4 units, and log2 TU size. Emits a stream of absolute per-component TU coordinates to the intra prediction front end, in order Y, Cb, Cr. Chroma format and CTB size are parameters. Handles 4:2:0, 4:2:2 (two stacked chroma squares) and monochrome, and merges chroma for 4x4 luma quads.

Parameters:
CHROMA_FMT, 1, chroma format: 0 = monochrome, 1 = 4:2:0, 2 = 4:2:2, 3 = 4:4:4
CTB_LOG2, 6, log2 luma CTB size (4..6)
XCTB_W, 9, width of the CTB index inputs
COORD_W, 13, width of the absolute coordinate outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_valid  in  1  input descriptor valid
i_ready  out  1  block can accept a descriptor this cycle
xCtb  in  XCTB_W  CTB column index
yCtb  in  XCTB_W  CTB row index
xTb_rela  in  CTB_LOG2-2  TU x offset in the CTB, 4-sample units
yTb_rela  in  CTB_LOG2-2  TU y offset in the CTB, 4-sample units
i_tuSize  in  3  log2 luma TU size (2..5)
o_valid  out  1  output TU valid
o_ready  in  1  downstream accepts the output TU
o_xTb  out  COORD_W  absolute x of the TU in its component plane
o_yTb  out  COORD_W  absolute y of the TU in its component plane
o_tuSize  out  3  log2 TU size in its component
o_cIdx  out  2  component: 0 = Y, 1 = Cb, 2 = Cr
o_last  out  1  final output for the current descriptor

Behaviour:
- Reset: state IDLE. o_valid, o_xTb, o_yTb, o_tuSize, o_cIdx and o_last are all 0. Reset mid-sequence discards the held descriptor and any pending outputs.
- Luma coordinates: xL = (xCtb<<CTB_LOG2) + (xTb_rela<<2); same form for yL. Computed at COORD_W bits with zero extension.
- Acceptance: i_ready = (state==IDLE) || (o_valid && o_ready && o_last). A descriptor is captured on i_valid && i_ready.
- Latency: o_valid rises on the cycle after capture. Back-to-back descriptors stream with no bubble.
- Output hold: o_xTb, o_yTb, o_tuSize, o_cIdx and o_last stay stable while o_valid && !o_ready.
- States: IDLE, Y, CB0, CB1, CR0, CR1. Each output advances on o_valid && o_ready.
- Sequence by CHROMA_FMT:
  - 0: Y only.
  - 1 and 3: Y, CB0, CR0.
  - 2: Y, CB0, CB1, CR0, CR1.
- o_last is asserted on the final state of the sequence. After a last transfer the block returns to IDLE, or moves to Y if a new descriptor is captured in the same cycle.
- 4x4 quad merge (CHROMA_FMT 1 or 2, i_tuSize==2):
  - Chroma states are emitted only when xTb_rela[0] && yTb_rela[0], i.e. the last 4x4 of the z-order quad. Otherwise the Y output carries o_last=1.
  - Base of the merged area: xB = xL-4, yB = yL-4.
  - Chroma log2 size is 2.
- Chroma size rule, all other cases: log2 size = i_tuSize-1 for formats 1 and 2; i_tuSize for format 3.
- Chroma coordinates:
  - Format 1: (xB>>1, yB>>1) for quads, else (xL>>1, yL>>1).
  - Format 2: x as in format 1. The CB0/CR0 y is yB (quad) or yL. The CB1/CR1 y is that value + (1<<chroma log2 size).
  - Format 3: (xL, yL).
- Cb and Cr of the same descriptor carry identical coordinates and size.
- Input descriptors with i_tuSize outside 2..5 are undefined behaviour and are not checked.

Test Plan:
1. Reset check: CHROMA_FMT=1. Assert rst for 2 cycles with i_valid=1 -> o_valid=0 and all outputs 0 during reset; i_ready=1 the cycle after reset releases.
2. Plain 4:2:0 TU: CHROMA_FMT=1, xCtb=2, yCtb=1, xTb_rela=4, yTb_rela=8, i_tuSize=4, o_ready=1. Required outputs, one per cycle from capture+1:
   - (144, 96, 4, cIdx=0)
   - (72, 48, 3, cIdx=1)
   - (72, 48, 3, cIdx=2, last=1)
3. 4:2:0 quad merge: four descriptors xCtb=yCtb=0 with rela (0,0), (1,0), (0,1), (1,1), i_tuSize=2. Required:
   - First three produce Y only, each with o_last=1.
   - Fourth produces Y (4,4,2), then Cb (0,0,2), then Cr (0,0,2, last).
4. 4:2:2 TU: CHROMA_FMT=2, xCtb=0, yCtb=0, rela (2,2), i_tuSize=3. Required sequence:
   - Y (8,8,3)
   - Cb (4,8,2), Cb (4,12,2)
   - Cr (4,8,2), Cr (4,12,2, last)
5. Backpressure: CHROMA_FMT=1 with o_ready held low 5 cycles during the Cb output -> outputs held stable and i_ready=0. On release the sequence completes, and a waiting descriptor is captured in the same cycle as Cr transfers.
6. Monochrome and reset mid-sequence: CHROMA_FMT=0 stream of 3 descriptors -> one output per cycle, each with o_last=1. Separately, CHROMA_FMT=1 with rst pulsed during CB0 -> o_valid=0 next cycle, and the next accepted descriptor starts cleanly at Y.
